failure_table_loader: RTL and testbench



---
 rtl/ac_pkg.sv | 24 ++
 rtl/fail_tbl_mem.sv | 46 ++++
 rtl/failure_table_loader.sv | 186 ++++++++++++++++++
 tb/tb_failure_table_loader.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ac_pkg.sv
// ac_pkg: constants and types shared by the Aho-Corasick failure-table slice.
//   AC_DEPTH   number of automaton states (table entries)
//   AC_AW      table address width, clog2(AC_DEPTH)
//   AC_DW      state / failure word width
//   ROOT_STATE failure target used when clearing the table
//   load_st_e  loader FSM states
package ac_pkg;

    localparam int unsigned AC_DEPTH = 32;
    localparam int unsigned AC_AW    = 5;
    localparam int unsigned AC_DW    = 8;

    localparam logic [AC_DW-1:0] ROOT_STATE = 8'h00;

    typedef enum logic [2:0] {
        CLEAR  = 3'd0,
        IDLE   = 3'd1,
        PAIR_S = 3'd2,
        PAIR_F = 3'd3,
        CHECK  = 3'd4,
        FIN    = 3'd5
    } load_st_e;

endpackage

// File: rtl/fail_tbl_mem.sv
// fail_tbl_mem: DEPTH x DW failure-link storage.
//   CLK, RST  clock, synchronous active-high reset (clears the read register only)
//   we_i      write enable; waddr_i / wdata_i written on the rising edge
//   raddr_i   lookup address
//   rdata_o   registered lookup data, one cycle after raddr_i
// A read and a write to the same address on one edge return the old contents.
module fail_tbl_mem
    import ac_pkg::*;
#(
    parameter int unsigned DEPTH = AC_DEPTH,
    parameter int unsigned AW    = AC_AW,
    parameter int unsigned DW    = AC_DW
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    // Storage is not reset; the loader's CLEAR sweep initialises it.
    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_d, rdata_q;

    always_ff @(posedge CLK) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_comb begin
        rdata_d = mem_q[raddr_i];
        if (RST) begin
            rdata_d = '0;
        end
    end

    always_ff @(posedge CLK) begin
        rdata_q <= rdata_d;
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/failure_table_loader.sv
// failure_table_loader: loads the Aho-Corasick failure-link table from a byte stream
// and serves the matcher's registered lookup.
//   CLK, RST       clock, synchronous active-high reset
//   IN_VALID/DATA  byte stream in; IN_READY high when a byte is accepted this cycle
//   ADDR_F         lookup address; FAILURE_STATE is table[ADDR_F] one cycle later
//   LOAD_BUSY      clearing or frame in progress
//   LOAD_DONE      one-cycle pulse at the end of every frame
//   LOAD_ERR       frame error, held until the next COUNT byte is accepted
//   TABLE_VALID    table holds a complete, checksum-good load
// Frame: COUNT N, N x (state, failure), CHK; the byte sum mod 256 must be zero.
module failure_table_loader
    import ac_pkg::*;
#(
    parameter int unsigned DEPTH = AC_DEPTH,
    parameter int unsigned AW    = AC_AW,
    parameter int unsigned DW    = AC_DW
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          IN_VALID,
    input  logic [7:0]    IN_DATA,
    output logic          IN_READY,
    input  logic [AW-1:0] ADDR_F,
    output logic [DW-1:0] FAILURE_STATE,
    output logic          LOAD_BUSY,
    output logic          LOAD_DONE,
    output logic          LOAD_ERR,
    output logic          TABLE_VALID
);

    load_st_e      state_d, state_q;
    logic [AW-1:0] clr_idx_d, clr_idx_q;
    logic [AW:0]   rem_d, rem_q;      // pairs still to come, holds up to DEPTH
    logic [7:0]    sum_d, sum_q;
    logic [7:0]    sbyte_d, sbyte_q;  // state byte of the pair in flight
    logic          err_d, err_q;
    logic          tv_d, tv_q;

    logic          accept;
    logic [7:0]    chk_sum;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;

    // Handshake and status are pure decodes of the registered state.
    always_comb begin
        IN_READY  = 1'b0;
        LOAD_BUSY = 1'b0;
        LOAD_DONE = 1'b0;
        unique case (state_q)
            CLEAR:  LOAD_BUSY = 1'b1;
            IDLE:   IN_READY  = 1'b1;
            PAIR_S: begin IN_READY = 1'b1; LOAD_BUSY = 1'b1; end
            PAIR_F: begin IN_READY = 1'b1; LOAD_BUSY = 1'b1; end
            CHECK:  begin IN_READY = 1'b1; LOAD_BUSY = 1'b1; end
            FIN:    LOAD_DONE = 1'b1;
            default: LOAD_BUSY = 1'b1;
        endcase
    end

    assign accept  = IN_VALID && IN_READY;
    assign chk_sum = sum_q + IN_DATA;

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        rem_d     = rem_q;
        sum_d     = sum_q;
        sbyte_d   = sbyte_q;
        err_d     = err_q;
        tv_d      = tv_q;
        mem_we    = 1'b0;
        mem_waddr = clr_idx_q;
        mem_wdata = ROOT_STATE;

        unique case (state_q)
            CLEAR: begin
                mem_we    = 1'b1;
                clr_idx_d = clr_idx_q + 1'b1;
                if (clr_idx_q == AW'(DEPTH - 1)) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (accept) begin
                    tv_d  = 1'b0;
                    sum_d = IN_DATA;
                    rem_d = IN_DATA[AW:0];
                    if ((IN_DATA == 8'h00) || (IN_DATA > 8'(DEPTH))) begin
                        err_d   = 1'b1;
                        state_d = FIN;
                    end else begin
                        err_d   = 1'b0;
                        state_d = PAIR_S;
                    end
                end
            end
            PAIR_S: begin
                if (accept) begin
                    sbyte_d = IN_DATA;
                    sum_d   = chk_sum;
                    state_d = PAIR_F;
                end
            end
            PAIR_F: begin
                if (accept) begin
                    sum_d = chk_sum;
                    // Out-of-range states would alias onto a real entry, so drop them.
                    if (sbyte_q < 8'(DEPTH)) begin
                        mem_we    = 1'b1;
                        mem_waddr = sbyte_q[AW-1:0];
                        mem_wdata = IN_DATA[DW-1:0];
                    end else begin
                        err_d = 1'b1;
                    end
                    rem_d = rem_q - 1'b1;
                    if (rem_q == (AW+1)'(1)) begin
                        state_d = CHECK;
                    end else begin
                        state_d = PAIR_S;
                    end
                end
            end
            CHECK: begin
                if (accept) begin
                    sum_d = chk_sum;
                    if (chk_sum != 8'h00) begin
                        err_d = 1'b1;
                    end
                    // Raised here so it is already visible alongside LOAD_DONE in FIN.
                    tv_d    = !err_q && (chk_sum == 8'h00);
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = CLEAR;
            end
        endcase

        // A frame aborted by reset must not touch the table.
        if (RST) begin
            mem_we = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= CLEAR;
            clr_idx_q <= '0;
            rem_q     <= '0;
            sum_q     <= '0;
            sbyte_q   <= '0;
            err_q     <= 1'b0;
            tv_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            rem_q     <= rem_d;
            sum_q     <= sum_d;
            sbyte_q   <= sbyte_d;
            err_q     <= err_d;
            tv_q      <= tv_d;
        end
    end

    assign LOAD_ERR    = err_q;
    assign TABLE_VALID = tv_q;

    fail_tbl_mem #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_mem (
        .CLK     (CLK),
        .RST     (RST),
        .we_i    (mem_we),
        .waddr_i (mem_waddr),
        .wdata_i (mem_wdata),
        .raddr_i (ADDR_F),
        .rdata_o (FAILURE_STATE)
    );

endmodule

// File: tb/tb_failure_table_loader.sv
// Directed bench for failure_table_loader; inputs change and outputs are sampled 1ns
// after each rising edge.
module tb_failure_table_loader;

    logic       CLK;
    logic       RST;
    logic       IN_VALID;
    logic [7:0] IN_DATA;
    logic       IN_READY;
    logic [4:0] ADDR_F;
    logic [7:0] FAILURE_STATE;
    logic       LOAD_BUSY;
    logic       LOAD_DONE;
    logic       LOAD_ERR;
    logic       TABLE_VALID;

    int checks;
    int failures;

    failure_table_loader dut (
        .CLK           (CLK),
        .RST           (RST),
        .IN_VALID      (IN_VALID),
        .IN_DATA       (IN_DATA),
        .IN_READY      (IN_READY),
        .ADDR_F        (ADDR_F),
        .FAILURE_STATE (FAILURE_STATE),
        .LOAD_BUSY     (LOAD_BUSY),
        .LOAD_DONE     (LOAD_DONE),
        .LOAD_ERR      (LOAD_ERR),
        .TABLE_VALID   (TABLE_VALID)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Offers one byte and waits (bounded) for it to be taken; returns 1ns after that edge.
    task automatic send_byte(input logic [7:0] b);
        int waited;
        waited   = 0;
        IN_VALID = 1'b1;
        IN_DATA  = b;
        while (!IN_READY && waited < 64) begin
            step();
            waited++;
        end
        if (!IN_READY) begin
            failures++;
            $display("FAIL send_byte_timeout byte=%02h ready=%b required=1", b, IN_READY);
        end
        step();
        IN_VALID = 1'b0;
    endtask

    task automatic test_reset();
        RST      = 1'b1;
        IN_VALID = 1'b0;
        IN_DATA  = 8'h00;
        ADDR_F   = 5'd0;
        step();
        step();
        checks++;
        if (LOAD_BUSY !== 1'b1 || IN_READY !== 1'b0 || LOAD_DONE !== 1'b0 ||
            LOAD_ERR !== 1'b0 || TABLE_VALID !== 1'b0 || FAILURE_STATE !== 8'h00) begin
            failures++;
            $display("FAIL reset_values got busy=%b rdy=%b done=%b err=%b tv=%b fs=%02h required 1 0 0 0 0 00",
                     LOAD_BUSY, IN_READY, LOAD_DONE, LOAD_ERR, TABLE_VALID, FAILURE_STATE);
        end
        RST = 1'b0;
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (LOAD_BUSY !== 1'b1 || IN_READY !== 1'b0) begin
                failures++;
                $display("FAIL clear_busy cycle=%0d busy=%b rdy=%b required busy=1 rdy=0",
                         i, LOAD_BUSY, IN_READY);
            end
            step();
        end
        checks++;
        if (IN_READY !== 1'b1 || LOAD_BUSY !== 1'b0 || LOAD_DONE !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_clear rdy=%b busy=%b done=%b required 1 0 0",
                     IN_READY, LOAD_BUSY, LOAD_DONE);
        end
        for (int a = 0; a < 32; a++) begin
            ADDR_F = 5'(a);
            step();
            checks++;
            if (FAILURE_STATE !== 8'h00) begin
                failures++;
                $display("FAIL clear_read addr=%0d got=%02h required=00", a, FAILURE_STATE);
            end
        end
    endtask

    task automatic test_bad_chk();
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h01);
        send_byte(8'h05);
        send_byte(8'h02);
        send_byte(8'hF4);
        checks++;
        if (LOAD_DONE !== 1'b1 || LOAD_ERR !== 1'b1 || TABLE_VALID !== 1'b0) begin
            failures++;
            $display("FAIL bad_chk_fin done=%b err=%b tv=%b required 1 1 0",
                     LOAD_DONE, LOAD_ERR, TABLE_VALID);
        end
        ADDR_F = 5'd3;
        step();
        checks++;
        if (FAILURE_STATE !== 8'h01 || LOAD_DONE !== 1'b0 || LOAD_ERR !== 1'b1) begin
            failures++;
            $display("FAIL bad_chk_partial fs=%02h done=%b err=%b required 01 0 1",
                     FAILURE_STATE, LOAD_DONE, LOAD_ERR);
        end
    endtask

    task automatic test_good_frame();
        send_byte(8'h02);
        checks++;
        if (LOAD_ERR !== 1'b0 || LOAD_BUSY !== 1'b1 || TABLE_VALID !== 1'b0) begin
            failures++;
            $display("FAIL good_count err=%b busy=%b tv=%b required 0 1 0",
                     LOAD_ERR, LOAD_BUSY, TABLE_VALID);
        end
        send_byte(8'h03);
        send_byte(8'h01);
        send_byte(8'h05);
        send_byte(8'h02);
        send_byte(8'hF3);
        checks++;
        if (LOAD_DONE !== 1'b1 || LOAD_ERR !== 1'b0 || TABLE_VALID !== 1'b1 ||
            LOAD_BUSY !== 1'b0 || IN_READY !== 1'b0) begin
            failures++;
            $display("FAIL good_fin done=%b err=%b tv=%b busy=%b rdy=%b required 1 0 1 0 0",
                     LOAD_DONE, LOAD_ERR, TABLE_VALID, LOAD_BUSY, IN_READY);
        end
        ADDR_F = 5'd5;
        step();
        checks++;
        if (FAILURE_STATE !== 8'h02 || LOAD_DONE !== 1'b0 || IN_READY !== 1'b1 ||
            TABLE_VALID !== 1'b1) begin
            failures++;
            $display("FAIL good_after fs=%02h done=%b rdy=%b tv=%b required 02 0 1 1",
                     FAILURE_STATE, LOAD_DONE, IN_READY, TABLE_VALID);
        end
        ADDR_F = 5'd3;
        step();
        checks++;
        if (FAILURE_STATE !== 8'h01) begin
            failures++;
            $display("FAIL good_read3 got=%02h required=01", FAILURE_STATE);
        end
    endtask

    task automatic test_bad_count();
        logic [7:0] counts [2];
        counts[0] = 8'h00;
        counts[1] = 8'h21;
        for (int i = 0; i < 2; i++) begin
            send_byte(counts[i]);
            checks++;
            if (LOAD_DONE !== 1'b1 || LOAD_ERR !== 1'b1 || TABLE_VALID !== 1'b0) begin
                failures++;
                $display("FAIL bad_count_fin n=%02h done=%b err=%b tv=%b required 1 1 0",
                         counts[i], LOAD_DONE, LOAD_ERR, TABLE_VALID);
            end
            step();
            checks++;
            if (LOAD_DONE !== 1'b0 || IN_READY !== 1'b1 || LOAD_ERR !== 1'b1) begin
                failures++;
                $display("FAIL bad_count_idle n=%02h done=%b rdy=%b err=%b required 0 1 1",
                         counts[i], LOAD_DONE, IN_READY, LOAD_ERR);
            end
        end
    endtask

    task automatic test_bad_state();
        // 02 + 25 + 01 + 04 + 09 = 35, checksum CB
        send_byte(8'h02);
        send_byte(8'h25);
        send_byte(8'h01);
        send_byte(8'h04);
        send_byte(8'h09);
        send_byte(8'hCB);
        checks++;
        if (LOAD_DONE !== 1'b1 || LOAD_ERR !== 1'b1 || TABLE_VALID !== 1'b0) begin
            failures++;
            $display("FAIL bad_state_fin done=%b err=%b tv=%b required 1 1 0",
                     LOAD_DONE, LOAD_ERR, TABLE_VALID);
        end
        ADDR_F = 5'd4;
        step();
        checks++;
        if (FAILURE_STATE !== 8'h09) begin
            failures++;
            $display("FAIL bad_state_write4 got=%02h required=09", FAILURE_STATE);
        end
        ADDR_F = 5'd5;
        step();
        checks++;
        if (FAILURE_STATE !== 8'h02) begin
            failures++;
            $display("FAIL bad_state_nowrite5 got=%02h required=02", FAILURE_STATE);
        end
    endtask

    task automatic test_rw_collision();
        // 01 + 03 + 07 = 0B, checksum F5
        send_byte(8'h01);
        send_byte(8'h03);
        ADDR_F   = 5'd3;
        IN_VALID = 1'b1;
        IN_DATA  = 8'h07;
        checks++;
        if (IN_READY !== 1'b1) begin
            failures++;
            $display("FAIL collide_ready got=%b required=1", IN_READY);
        end
        step();
        IN_VALID = 1'b0;
        checks++;
        if (FAILURE_STATE !== 8'h01) begin
            failures++;
            $display("FAIL collide_old got=%02h required=01", FAILURE_STATE);
        end
        step();
        checks++;
        if (FAILURE_STATE !== 8'h07) begin
            failures++;
            $display("FAIL collide_new got=%02h required=07", FAILURE_STATE);
        end
        send_byte(8'hF5);
        checks++;
        if (LOAD_DONE !== 1'b1 || LOAD_ERR !== 1'b0 || TABLE_VALID !== 1'b1) begin
            failures++;
            $display("FAIL collide_fin done=%b err=%b tv=%b required 1 0 1",
                     LOAD_DONE, LOAD_ERR, TABLE_VALID);
        end
        step();
    endtask

    task automatic test_reset_mid_frame();
        send_byte(8'h01);
        send_byte(8'h03);
        IN_VALID = 1'b1;
        IN_DATA  = 8'h0A;
        RST      = 1'b1;
        step();
        IN_VALID = 1'b0;
        RST      = 1'b0;
        checks++;
        if (LOAD_BUSY !== 1'b1 || IN_READY !== 1'b0 || TABLE_VALID !== 1'b0 ||
            LOAD_ERR !== 1'b0 || FAILURE_STATE !== 8'h00) begin
            failures++;
            $display("FAIL midrst_state busy=%b rdy=%b tv=%b err=%b fs=%02h required 1 0 0 0 00",
                     LOAD_BUSY, IN_READY, TABLE_VALID, LOAD_ERR, FAILURE_STATE);
        end
        for (int i = 0; i < 32; i++) begin
            step();
        end
        checks++;
        if (IN_READY !== 1'b1 || LOAD_BUSY !== 1'b0) begin
            failures++;
            $display("FAIL midrst_idle rdy=%b busy=%b required 1 0", IN_READY, LOAD_BUSY);
        end
        for (int a = 3; a < 6; a++) begin
            ADDR_F = 5'(a);
            step();
            checks++;
            if (FAILURE_STATE !== 8'h00) begin
                failures++;
                $display("FAIL midrst_read addr=%0d got=%02h required=00", a, FAILURE_STATE);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_bad_chk();
        test_good_frame();
        test_bad_count();
        test_bad_state();
        test_rw_collision();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
